// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: per-stage pipeline-register enables, flushes and DM access sequencing.
// Define PIPE_STALL_CNT_EN to add the 32-bit stall/flush event counters.
module pipe_stall_ctrl #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  im_busy,
   input  logic                  dm_req,
   input  logic                  dm_done,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic                  ex_branch_taken,
   output logic                  dm_start,
   output logic                  PC_write,
   output logic                  IF_ID_Reg_Write,
   output logic                  ID_EX_Reg_Write,
   output logic                  EX_MEM_Reg_Write,
   output logic                  MEM_WB_Reg_Write,
   output logic                  IF_ID_flush,
   output logic                  ID_EX_flush
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [31:0]           cnt_mem_stall,
   output logic [31:0]           cnt_lu_stall,
   output logic [31:0]           cnt_flush
`endif
);

   localparam logic [1:0] ST_BOOT    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_DM_WAIT = 2'd2;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic       dm_served_r;
   logic       dm_served_nxt_s;

   logic       in_run_s;
   logic       in_wait_s;
   logic       in_boot_s;
   logic       issue_s;
   logic       mem_stall_s;
   logic       global_stall_s;
   logic       rs1_hit_s;
   logic       rs2_hit_s;
   logic       load_use_s;

   logic       pc_we_s;
   logic       if_id_we_s;
   logic       id_ex_we_s;
   logic       ex_mem_we_s;
   logic       mem_wb_we_s;
   logic       if_id_fl_s;
   logic       id_ex_fl_s;
   logic       lu_bubble_s;
   logic       br_flush_s;

   // Any encoding other than RUN/DM_WAIT is treated like BOOT so a corrupted state freezes the pipe.
   assign in_run_s  = (state_r == ST_RUN);
   assign in_wait_s = (state_r == ST_DM_WAIT);
   assign in_boot_s = ~(in_run_s | in_wait_s);

   // dm_served blocks a re-issue of an access that completed while the stages were frozen.
   assign issue_s        = in_run_s & dm_req & ~dm_served_r;
   assign mem_stall_s    = issue_s | (in_wait_s & ~dm_done);
   assign global_stall_s = im_busy | mem_stall_s | in_boot_s;

   assign rs1_hit_s  = id_rs1_used & (id_rs1_addr == ex_rd_addr);
   assign rs2_hit_s  = id_rs2_used & (id_rs2_addr == ex_rd_addr);
   assign load_use_s = ex_mem_read & (ex_rd_addr != REG_ZERO) & (rs1_hit_s | rs2_hit_s);

   // Next-state logic for the DM access sequencer.
   always_comb begin
      state_nxt_s = ST_BOOT;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s = ST_RUN;
         end
         ST_RUN: begin
            if (issue_s) begin
               state_nxt_s = ST_DM_WAIT;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DM_WAIT: begin
            if (dm_done) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_DM_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_BOOT;
         end
      endcase
   end

   // Hazard resolution in fixed priority: freeze, branch flush, load-use bubble, normal flow.
   always_comb begin
      pc_we_s     = 1'b0;
      if_id_we_s  = 1'b0;
      id_ex_we_s  = 1'b0;
      ex_mem_we_s = 1'b0;
      mem_wb_we_s = 1'b0;
      if_id_fl_s  = 1'b0;
      id_ex_fl_s  = 1'b0;
      lu_bubble_s = 1'b0;
      br_flush_s  = 1'b0;
      if (global_stall_s) begin
         pc_we_s     = 1'b0;
         if_id_we_s  = 1'b0;
         id_ex_we_s  = 1'b0;
         ex_mem_we_s = 1'b0;
         mem_wb_we_s = 1'b0;
      end else if (ex_branch_taken) begin
         pc_we_s     = 1'b1;
         if_id_we_s  = 1'b1;
         id_ex_we_s  = 1'b1;
         ex_mem_we_s = 1'b1;
         mem_wb_we_s = 1'b1;
         if_id_fl_s  = 1'b1;
         id_ex_fl_s  = 1'b1;
         br_flush_s  = 1'b1;
      end else if (load_use_s) begin
         id_ex_we_s  = 1'b1;
         ex_mem_we_s = 1'b1;
         mem_wb_we_s = 1'b1;
         id_ex_fl_s  = 1'b1;
         lu_bubble_s = 1'b1;
      end else begin
         pc_we_s     = 1'b1;
         if_id_we_s  = 1'b1;
         id_ex_we_s  = 1'b1;
         ex_mem_we_s = 1'b1;
         mem_wb_we_s = 1'b1;
      end
   end

   // A release in the same cycle as MEM/WB advancing means the served instruction has moved on.
   always_comb begin
      dm_served_nxt_s = dm_served_r;
      if (mem_wb_we_s) begin
         dm_served_nxt_s = 1'b0;
      end else if (in_wait_s & dm_done) begin
         dm_served_nxt_s = 1'b1;
      end else begin
         dm_served_nxt_s = dm_served_r;
      end
   end

   // State and served-flag registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_BOOT;
         dm_served_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         dm_served_r <= dm_served_nxt_s;
      end
   end

   // Outputs are forced low whenever reset is asserted, independent of the current state.
   assign dm_start         = rst & issue_s;
   assign PC_write         = rst & pc_we_s;
   assign IF_ID_Reg_Write  = rst & if_id_we_s;
   assign ID_EX_Reg_Write  = rst & id_ex_we_s;
   assign EX_MEM_Reg_Write = rst & ex_mem_we_s;
   assign MEM_WB_Reg_Write = rst & mem_wb_we_s;
   assign IF_ID_flush      = rst & if_id_fl_s;
   assign ID_EX_flush      = rst & id_ex_fl_s;

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] cnt_mem_stall_r;
   logic [31:0] cnt_lu_stall_r;
   logic [31:0] cnt_flush_r;

   // Event counters; they wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_mem_stall_r <= 32'd0;
         cnt_lu_stall_r  <= 32'd0;
         cnt_flush_r     <= 32'd0;
      end else begin
         if (global_stall_s && !in_boot_s) begin
            cnt_mem_stall_r <= cnt_mem_stall_r + 32'd1;
         end
         if (lu_bubble_s) begin
            cnt_lu_stall_r <= cnt_lu_stall_r + 32'd1;
         end
         if (br_flush_s) begin
            cnt_flush_r <= cnt_flush_r + 32'd1;
         end
      end
   end

   assign cnt_mem_stall = cnt_mem_stall_r;
   assign cnt_lu_stall  = cnt_lu_stall_r;
   assign cnt_flush     = cnt_flush_r;
`endif

endmodule
